// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// next_rr scans a 16-wide request vector; unused upper lanes must be tied to 0.
package adder_arb_pkg;

  localparam int STAT_W = 16;
  localparam int MAXREQ = 16;
  localparam int MAXIDW = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  typedef struct packed {
    logic              found;
    logic [MAXIDW-1:0] idx;
  } rr_t;

  // Zero-padded lanes above NREQ make the mod-16 wrap equivalent to mod-NREQ.
  function automatic rr_t next_rr(input logic [MAXREQ-1:0] valid,
                                  input logic [MAXIDW-1:0] ptr);
    rr_t               r;
    logic [MAXIDW-1:0] cand;
    r = '0;
    for (int k = 0; k < MAXREQ; k++) begin
      cand = ptr + k[MAXIDW-1:0];
      if (!r.found && valid[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_adder.sv
// Purely combinational unsigned adder: zero latency, no flow control.
// carry is bit N of the zero-extended sum.
module adder_rr_arbiter_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] termA,
  input  logic [N-1:0] termB,
  output logic [N-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, termA} + {1'b0, termB};

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin share of one adder among NREQ requesters; result registered one cycle after grant,
// req_ready all-zero while the result slot is held. Per-requester counters with ADDER_ARB_STATS_EN.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*N-1:0]     req_a,
  input  logic [NREQ*N-1:0]     req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [N-1:0]          rsp_sum,
  output logic                  rsp_carry,
`ifdef ADDER_ARB_STATS_EN
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [NREQ*STAT_W-1:0] stat_cnt
`else
  output logic [$clog2(NREQ)-1:0] rsp_id
`endif
);

  localparam int IDW = $clog2(NREQ);

  slot_t             state, state_nxt;
  logic [IDW-1:0]    ptr;
  logic              can_accept;
  logic              xfer;
  logic [MAXREQ-1:0] valid_pad;
  logic [MAXIDW-1:0] ptr_pad;
  rr_t               rr;
  logic [IDW-1:0]    gnt;
  logic [N-1:0]      op_a, op_b;
  logic [N-1:0]      add_sum;
  logic              add_carry;
  logic              unused_rr_hi;

  assign can_accept = (state == EMPTY) || rsp_ready;

  always_comb begin
    valid_pad             = '0;
    valid_pad[NREQ-1:0]   = req_valid;
    ptr_pad               = '0;
    ptr_pad[IDW-1:0]      = ptr;
  end

  assign rr           = next_rr(valid_pad, ptr_pad);
  assign gnt          = rr.idx[IDW-1:0];
  assign unused_rr_hi = ^rr.idx;

  // Gated by rst_n so no grant is visible while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && can_accept && rr.found)
      req_ready[gnt] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);
  assign op_a = req_a[gnt*N +: N];
  assign op_b = req_b[gnt*N +: N];

  adder_rr_arbiter_adder #(.N(N)) u_adder (
    .termA (op_a),
    .termB (op_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_nxt = state;
    if (xfer)
      state_nxt = FULL;
    else if (rsp_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ptr       <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        rsp_sum   <= add_sum;
        rsp_carry <= add_carry;
        rsp_id    <= gnt;
        ptr       <= gnt + 1'b1;  // power-of-two NREQ wraps naturally
      end
    end
  end

  assign rsp_valid = (state == FULL);

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer && (gnt == i[IDW-1:0]) && (stat_cnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}))
          stat_cnt[i*STAT_W +: STAT_W] <= stat_cnt[i*STAT_W +: STAT_W] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter that shares one N-bit combinational adder among NREQ requesters. Each requester presents an operand pair on a valid/ready handshake. The winner's operands go through the shared adder, and the sum, carry and requester ID are registered into a single output slot with its own valid/ready handshake. It sits between the operand-producing clients and any consumer of adder results.

## Interface
- N, default 8: operand and sum width.
- NREQ, default 4: number of requesters; power of two, 2..16.
- IDW, derived as $clog2(NREQ): requester ID width; localparam.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*N  operand A; requester i occupies bits [i*N +: N].
- req_b  input  NREQ*N  operand B; same packing as req_a.
- rsp_valid  output  1  result slot holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_sum  output  N  registered sum, (a+b) mod 2^N.
- rsp_carry  output  1  registered carry-out, bit N of a+b.
- rsp_id  output  IDW  index of the requester that produced the result.
- stat_cnt  output  NREQ*16  per-requester accepted-operation counters; present only with ADDER_ARB_STATS_EN.

## Operation
- Output slot has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY, or (FULL and rsp_ready). This allows back-to-back operation.
- Arbitration when can_accept is high:
  - Search req_valid starting at index ptr and wrapping modulo NREQ.
  - The first set bit is the winner g; req_ready[g]=1 and all other req_ready bits are 0.
  - If no req_valid bit is set, all req_ready bits are 0.
- When can_accept is low, all req_ready bits are 0.
- Transfer on requester g occurs when req_valid[g] and req_ready[g]. On the next edge:
  - rsp_sum, rsp_carry take the adder result of req_a[g], req_b[g].
  - rsp_id takes g; the slot goes to FULL.
  - ptr takes (g+1) mod NREQ.
- When a response is consumed and there is no new transfer in the same cycle, the slot goes to EMPTY. rsp_sum, rsp_carry and rsp_id hold their last values.
- ptr changes only on a transfer.
- Simultaneous consume and transfer in one cycle: the slot stays FULL with the new result. The old result is counted as consumed; no bubble is inserted.
- Requester rules:
  - Requesters must not make req_valid depend on req_ready.
  - A requester holds its operands stable while req_valid is high and req_ready is low.
  - req_valid may drop without a transfer.
- Arithmetic: {rsp_carry, rsp_sum} = zero-extended a + zero-extended b, N+1 bits wide, unsigned.

## Timing
- req_ready is combinational from req_valid, ptr, the slot state and rsp_ready; there is no registered path.
- Latency: transfer in cycle t gives rsp_valid=1 with the result in cycle t+1.
- Throughput: one result per cycle while rsp_ready stays high.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_* is frozen and all req_ready bits are 0.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- Reset values, forced asynchronously on rst_n low:
  - rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0.
  - ptr=0, stat_cnt=0.
  - req_ready=0 while rst_n is low.
- Reset mid-operation discards any pending result. The first grant after reset starts its search at index 0.

## Configuration
- ADDER_ARB_STATS_EN defined:
  - stat_cnt port exists.
  - Counter i increments by 1 on each transfer from requester i.
  - Counters saturate at 16'hFFFF and clear only on reset.
- ADDER_ARB_STATS_EN undefined: no stat_cnt port, no counter logic. All other behaviour is identical.

## Structure
- Shared package adder_arb_pkg holds:
  - localparam STAT_W=16.
  - The slot-state typedef (EMPTY, FULL).
  - A function next_rr(valid, ptr) that returns the winner index and a found flag.
- One sub-module: the team's existing combinational adder. Ports are termA, termB, sum, carry, with width matching N. It is fed from a mux selected by g.
- Arbiter, slot register and counters stay in the top module.

## Test plan
- Reset, single request:
  - Stimulus: assert rst_n low, then release it. Requester 2 presents a=8'd200, b=8'd100 with rsp_ready=1.
  - Response: req_ready[2] is high in the same cycle. The next cycle shows rsp_valid=1, rsp_sum=8'd44, rsp_carry=1, rsp_id=2.
- Round-robin:
  - Stimulus: all four req_valid held high, rsp_ready=1, each requester presenting a=i, b=1.
  - Response: grants in order 0,1,2,3,0. rsp_sum sequence is 1,2,3,4,1, with one result per cycle.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles with result 8'd255+8'd1 pending.
  - Response: rsp_sum=0 and rsp_carry=1 stay stable, all req_ready bits stay 0. Releasing rsp_ready gives the next result one cycle later.
- Simultaneous consume and transfer:
  - Stimulus: slot FULL, rsp_ready=1, requester 1 valid.
  - Response: rsp_valid stays 1, the result changes to requester 1's operands on the next edge, rsp_id=1.
- Reset mid-operation:
  - Stimulus: pull rst_n low while rsp_valid=1 and ptr=3.
  - Response: rsp_valid drops to 0 immediately. After release, with requesters 0 and 3 both valid, requester 0 is granted first.
- Statistics (ADDER_ARB_STATS_EN):
  - Stimulus: 70000 transfers from requester 0.
  - Response: counter 0 reads 16'hFFFF; the other counters read 0.
